// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        FAULT   = 3'd4
    } fetch_state_t;

    localparam int         INSTR_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

    // A PC is legal only when it lands on an instruction boundary
    function automatic logic pc_misaligned(input logic [1:0] i_lsb);
        return (i_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : Architectural PC register with load enable. The alignment
//                flag looks at the value about to be loaded so the sequencer
//                can divert to FAULT on the same edge as the load.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_misaligned
);

    logic [ADDR_W-1:0] r_pc;

    // Capture a new PC whenever the sequencer requests a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_pc;
        end
    end

    assign o_pc         = r_pc;
    assign o_misaligned = pc_misaligned(i_pc[1:0]);

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Multi-cycle instruction fetch stage. One outstanding memory
//                read at a time; the fetched instruction is held until the
//                downstream stage accepts it together with the next PC.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [ADDR_W-1:0]  StartPC,
    output logic               ImemReqValid,
    input  logic               ImemReqReady,
    output logic [ADDR_W-1:0]  ImemAddr,
    input  logic               ImemRespValid,
    input  logic [INSTR_W-1:0] ImemRespData,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    input  logic [ADDR_W-1:0]  NextPC,
    input  logic               NextPCValid,
    output logic               Fault,
    output logic [CNT_W-1:0]   RetireCount
);

    fetch_state_t       r_state;
    logic               r_req_valid;
    logic               r_instr_valid;
    logic               r_fault;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_retire_cnt;

    logic               w_accept;
    logic               w_pc_load;
    logic [ADDR_W-1:0]  w_pc_d;
    logic [ADDR_W-1:0]  w_pc;
    logic               w_pc_misaligned;

    // Downstream takes the instruction only when it also supplies the next PC
    assign w_accept  = (r_state == PRESENT) && InstrReady && NextPCValid;
    assign w_pc_load = (r_state == BOOT) || w_accept;
    assign w_pc_d    = (r_state == BOOT) ? StartPC : NextPC;

    fetch_pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc_reg (
        .clk          (CLK),
        .rst_n        (Reset_L),
        .i_load       (w_pc_load),
        .i_pc         (w_pc_d),
        .o_pc         (w_pc),
        .o_misaligned (w_pc_misaligned)
    );

    // Fetch sequencer; handshake outputs are registered alongside the state
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state       <= BOOT;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_instr       <= '0;
            r_retire_cnt  <= '0;
        end else begin
            unique case (r_state)
                BOOT: begin
                    if (w_pc_misaligned) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_state     <= ISSUE;
                        r_req_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Any response seen here belongs to no request of ours
                    if (ImemReqReady) begin
                        r_state     <= WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (ImemRespValid) begin
                        r_state       <= PRESENT;
                        r_instr       <= ImemRespData;
                        r_instr_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (w_accept) begin
                        // The instruction retires even if its successor PC is bad
                        r_retire_cnt  <= r_retire_cnt + CNT_W'(1);
                        r_instr_valid <= 1'b0;
                        if (w_pc_misaligned) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_req_valid <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    assign ImemReqValid = r_req_valid;
    assign ImemAddr     = w_pc;
    assign InstrValid   = r_instr_valid;
    assign Instr        = r_instr;
    assign InstrPC      = w_pc;
    assign Fault        = r_fault;
    assign RetireCount  = r_retire_cnt;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a transaction-level
//                reference model, directed scenarios and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;

    logic               CLK = 1'b0;
    logic               Reset_L;
    logic [ADDR_W-1:0]  StartPC;
    logic               ImemReqValid;
    logic               ImemReqReady;
    logic [ADDR_W-1:0]  ImemAddr;
    logic               ImemRespValid;
    logic [INSTR_W-1:0] ImemRespData;
    logic               InstrValid;
    logic               InstrReady;
    logic [INSTR_W-1:0] Instr;
    logic [ADDR_W-1:0]  InstrPC;
    logic [ADDR_W-1:0]  NextPC;
    logic               NextPCValid;
    logic               Fault;
    logic [CNT_W-1:0]   RetireCount;

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK           (CLK),
        .Reset_L       (Reset_L),
        .StartPC       (StartPC),
        .ImemReqValid  (ImemReqValid),
        .ImemReqReady  (ImemReqReady),
        .ImemAddr      (ImemAddr),
        .ImemRespValid (ImemRespValid),
        .ImemRespData  (ImemRespData),
        .InstrValid    (InstrValid),
        .InstrReady    (InstrReady),
        .Instr         (Instr),
        .InstrPC       (InstrPC),
        .NextPC        (NextPC),
        .NextPCValid   (NextPCValid),
        .Fault         (Fault),
        .RetireCount   (RetireCount)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the fetch stage is currently doing, in words
    bit              m_need_pc;     // waiting to pick up StartPC
    bit              m_requesting;  // request on the bus, not yet taken
    bit              m_awaiting;    // request taken, response outstanding
    bit              m_holding;     // instruction offered downstream
    bit              m_faulted;
    logic [63:0]     m_pc;
    logic [31:0]     m_instr;
    int unsigned     m_retired;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_need_pc    = 1'b1;
        m_requesting = 1'b0;
        m_awaiting   = 1'b0;
        m_holding    = 1'b0;
        m_faulted    = 1'b0;
        m_pc         = '0;
        m_instr      = '0;
        m_retired    = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge();
        if (!Reset_L) begin
            model_reset();
        end else if (m_need_pc) begin
            m_need_pc = 1'b0;
            m_pc      = StartPC;
            if (StartPC % 4 != 0) m_faulted = 1'b1;
            else                  m_requesting = 1'b1;
        end else if (m_requesting) begin
            if (ImemReqReady) begin
                m_requesting = 1'b0;
                m_awaiting   = 1'b1;
            end
        end else if (m_awaiting) begin
            if (ImemRespValid) begin
                m_instr    = ImemRespData;
                m_awaiting = 1'b0;
                m_holding  = 1'b1;
            end
        end else if (m_holding) begin
            if (InstrReady && NextPCValid) begin
                m_retired = (m_retired + 1) % (1 << CNT_W);
                m_pc      = NextPC;
                m_holding = 1'b0;
                if (NextPC % 4 != 0) m_faulted = 1'b1;
                else                 m_requesting = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("req_valid",   64'(ImemReqValid), 64'(m_requesting));
        chk("imem_addr",   ImemAddr,          m_pc);
        chk("instr_valid", 64'(InstrValid),   64'(m_holding));
        chk("instr",       64'(Instr),        64'(m_instr));
        chk("instr_pc",    InstrPC,           m_pc);
        chk("fault",       64'(Fault),        64'(m_faulted));
        chk("retire_cnt",  64'(RetireCount),  64'(m_retired));
    endtask

    // One clock: inputs already driven; update model at the edge, check at negedge
    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic idle_inputs();
        ImemReqReady  = 1'b0;
        ImemRespValid = 1'b0;
        ImemRespData  = '0;
        InstrReady    = 1'b0;
        NextPCValid   = 1'b0;
        NextPC        = '0;
    endtask

    task automatic do_reset(input logic [63:0] start);
        idle_inputs();
        StartPC = start;
        Reset_L = 1'b0;
        model_reset();
        step();
        step();
        Reset_L = 1'b1;
    endtask

    // Full fetch loop at minimum latency starting from a pending request
    task automatic fast_loop(input logic [63:0] npc, input logic [31:0] data);
        idle_inputs();
        ImemReqReady = 1'b1;
        step();
        idle_inputs();
        ImemRespValid = 1'b1;
        ImemRespData  = data;
        step();
        idle_inputs();
        InstrReady  = 1'b1;
        NextPCValid = 1'b1;
        NextPC      = npc;
        step();
        idle_inputs();
    endtask

    initial begin
        logic [63:0] v;

        // Reset state
        do_reset(64'h1000);
        chk("reset_req_valid", 64'(ImemReqValid), 64'h0);
        chk("reset_fault",     64'(Fault),        64'h0);
        chk("reset_addr",      ImemAddr,          64'h0);

        // First fetch after release
        step();
        chk("boot_req_valid", 64'(ImemReqValid), 64'h1);
        chk("boot_addr",      ImemAddr,          64'h1000);
        chk("boot_fault",     64'(Fault),        64'h0);

        // Minimum-latency loop
        ImemReqReady = 1'b1;
        step();
        idle_inputs();
        ImemRespValid = 1'b1;
        ImemRespData  = 32'h8B020020;
        step();
        chk("lit_instr_valid", 64'(InstrValid), 64'h1);
        chk("lit_instr",       64'(Instr),      64'h8B020020);
        chk("lit_instr_pc",    InstrPC,         64'h1000);
        idle_inputs();
        InstrReady  = 1'b1;
        NextPCValid = 1'b1;
        NextPC      = 64'h1004;
        step();
        idle_inputs();
        chk("lit_next_addr", ImemAddr,           64'h1004);
        chk("lit_next_req",  64'(ImemReqValid),  64'h1);
        chk("lit_retire1",   64'(RetireCount),   64'h1);

        // Memory stalls the request while stray responses arrive
        for (int i = 0; i < 4; i++) begin
            ImemRespValid = 1'b1;
            ImemRespData  = $urandom();
            step();
            chk("stall_addr", ImemAddr, 64'h1004);
        end
        idle_inputs();
        ImemReqReady = 1'b1;
        step();
        idle_inputs();
        ImemRespValid = 1'b1;
        ImemRespData  = 32'hD503201F;
        step();
        // Downstream ready but next PC not yet available
        idle_inputs();
        InstrReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_instr", 64'(Instr), 64'hD503201F);
        end
        chk("hold_retire", 64'(RetireCount), 64'h1);
        NextPCValid = 1'b1;
        NextPC      = 64'h0FF0;
        step();
        idle_inputs();
        chk("branch_addr", ImemAddr, 64'h0FF0);

        // Misaligned successor: retires, then faults
        fast_loop(64'h1006, 32'h12345678);
        chk("lit_fault",       64'(Fault),        64'h1);
        chk("lit_fault_count", 64'(RetireCount),  64'h3);
        ImemReqReady  = 1'b1;
        ImemRespValid = 1'b1;
        InstrReady    = 1'b1;
        NextPCValid   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("fault_no_req", 64'(ImemReqValid), 64'h0);

        // Reset while a response is outstanding; late response ignored
        do_reset(64'h2000);
        step();
        ImemReqReady = 1'b1;
        step();
        idle_inputs();
        do_reset(64'h3000);
        ImemRespValid = 1'b1;
        ImemRespData  = 32'hDEADBEEF;
        step();
        step();
        chk("restart_addr",  ImemAddr,           64'h3000);
        chk("restart_instr", 64'(InstrValid),    64'h0);
        idle_inputs();

        // Misaligned start PC
        do_reset(64'h1002);
        step();
        chk("start_fault", 64'(Fault),        64'h1);
        chk("start_noreq", 64'(ImemReqValid), 64'h0);

        // Counter wrap
        do_reset(64'h4000);
        step();
        for (int i = 0; i < 15; i++) fast_loop(64'h4004 + 64'(4 * i), $urandom());
        chk("wrap_15", 64'(RetireCount), 64'hF);
        fast_loop(64'h5000, 32'h0);
        chk("wrap_0", 64'(RetireCount), 64'h0);

        // Randomized traffic
        do_reset(64'h8000);
        for (int i = 0; i < 3000; i++) begin
            if ((m_faulted && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
                v = {$urandom(), $urandom()};
                if ($urandom_range(0, 9) != 0) v[1:0] = 2'b00;
                do_reset(v);
            end
            ImemReqReady  = ($urandom_range(0, 2) != 0);
            ImemRespValid = ($urandom_range(0, 1) != 0);
            ImemRespData  = $urandom();
            InstrReady    = ($urandom_range(0, 2) != 0);
            NextPCValid   = ($urandom_range(0, 2) != 0);
            v = {$urandom(), $urandom()};
            if ($urandom_range(0, 49) != 0) v[1:0] = 2'b00;
            NextPC = v;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
